display_stream: RTL and testbench

- Parametrised single-clock display engine. Generates raster timing and accepts a packed pixel stream through valid/ready into an internal word FIFO.
- Unpacks each word into PIX_W-bit pixels and drives registered sync and RGB outputs.
- Start/stop commands gate streaming. A test pattern fills the screen whenever the engine is not running.
- Successor to the fixed 640x480 8-bit grey display path. Adds programmable timing, 8- or 24-bit pixels, a clean stop at frame end, an underflow flag and a frame counter.

---
 rtl/display_stream_if.sv | 15 +
 rtl/display_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_display_stream.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_stream_if.sv
// Command and packed-pixel stream handshake bundle between a stream source
// (master) and the display engine (slave).
interface display_stream_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output cmd, cmd_valid, s_data, s_valid, input cmd_ready, s_ready);
    modport slave  (input cmd, cmd_valid, s_data, s_valid, output cmd_ready, s_ready);
endinterface

// File: rtl/display_stream.sv
// Raster display engine: programmable timing, word FIFO, pixel unpacker,
// start/stop control with a clean frame-end stop, and registered VGA pins.
module display_stream #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int DATA_W      = 64,
    parameter int PIX_W       = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8
) (
    input  logic                          vgaclk,
    input  logic                          rst,
    display_stream_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          VGA_HS_n,
    output logic                          VGA_VS_n,
    output logic [7:0]                    VGA_red,
    output logic [7:0]                    VGA_green,
    output logic [7:0]                    VGA_blue,
    output logic                          running,
    output logic                          underflow,
    output logic [15:0]                   frames_shown
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int NPIX    = DATA_W / PIX_W;
    localparam int IDX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_STOPPING} state_t;

    state_t              r_state, w_state_next;
    logic [HC_W-1:0]     r_hcnt;
    logic [VC_W-1:0]     r_vcnt;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [DATA_W-1:0]   r_word, w_word_next, w_head;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic                r_full, w_full_next;
    logic                w_frame_end, w_active, w_start, w_stop, w_go, w_streaming;
    logic                w_stream, w_flush, w_consume, w_wr, w_rd, w_under, w_fifo_empty;
    logic [PIX_W-1:0]    w_pix;
    logic [23:0]         w_pix24, w_rgb;

    function automatic logic [PIX_W-1:0] pick(input logic [DATA_W-1:0] word,
                                              input logic [IDX_W-1:0]  idx);
        logic [DATA_W-1:0] sh;
        sh = word >> (PIX_W * (NPIX - 1 - int'(idx)));
        return sh[PIX_W-1:0];
    endfunction

    assign w_frame_end  = (int'(r_hcnt) == H_TOTAL - 1) && (int'(r_vcnt) == V_TOTAL - 1);
    assign w_active     = (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
    assign w_start      = bus.cmd_valid && (bus.cmd == 32'd1);
    assign w_stop       = bus.cmd_valid && (bus.cmd == 32'd2);
    assign w_go         = (r_state == ST_ARMED) && !w_stop && (r_hcnt == '0) && (r_vcnt == '0)
                          && (int'(r_count) >= START_LEVEL);
    assign w_streaming  = (r_state == ST_RUN) || (r_state == ST_STOPPING);
    assign w_stream     = w_streaming || w_go;
    assign w_flush      = (r_state == ST_STOPPING) && w_frame_end;
    assign w_consume    = w_stream && w_active;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    // Words arriving on the flush cycle are discarded along with the FIFO contents.
    assign w_wr         = bus.s_valid && bus.s_ready && !w_flush;

    assign bus.cmd_ready = 1'b1;
    assign bus.s_ready   = (int'(r_count) < FIFO_DEPTH);
    assign fifo_count    = r_count;
    assign running       = w_streaming;

    // Raster counters: free-running, never stalled by the stream.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (int'(r_hcnt) == H_TOTAL - 1) begin
            r_hcnt <= '0;
            r_vcnt <= (int'(r_vcnt) == V_TOTAL - 1) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode; STOP wins over a simultaneous start of streaming.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_start)     w_state_next = ST_ARMED;    else w_state_next = ST_IDLE;
            ST_ARMED:    if (w_stop)      w_state_next = ST_IDLE;
                         else if (w_go)   w_state_next = ST_RUN;      else w_state_next = ST_ARMED;
            ST_RUN:      if (w_stop)      w_state_next = ST_STOPPING; else w_state_next = ST_RUN;
            ST_STOPPING: if (w_frame_end) w_state_next = ST_IDLE;     else w_state_next = ST_STOPPING;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge vgaclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.s_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Unpacker: an empty register takes pixel 0 straight from the FIFO head,
    // and the last pixel of a word prefetches the next word, so no bubbles.
    always_comb begin
        w_rd        = 1'b0;
        w_under     = 1'b0;
        w_pix       = '0;
        w_word_next = r_word;
        w_idx_next  = r_idx;
        w_full_next = r_full;
        if (w_flush) begin
            w_full_next = 1'b0;
            w_idx_next  = '0;
        end else if (w_consume) begin
            if (r_full) begin
                w_pix = pick(r_word, r_idx);
                if (r_idx == IDX_LAST) begin
                    w_idx_next = '0;
                    if (!w_fifo_empty) begin
                        w_rd        = 1'b1;
                        w_word_next = w_head;
                        w_full_next = 1'b1;
                    end else begin
                        w_full_next = 1'b0;
                    end
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end else if (!w_fifo_empty) begin
                w_rd        = 1'b1;
                w_pix       = pick(w_head, '0);
                w_word_next = w_head;
                w_idx_next  = (NPIX > 1) ? IDX_W'(1) : IDX_W'(0);
                w_full_next = (NPIX > 1);
            end else begin
                w_under = 1'b1;
            end
        end else begin
            w_full_next = r_full;
        end
    end

    // Unpack register.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else begin
            r_word <= w_word_next;
            r_idx  <= w_idx_next;
            r_full <= w_full_next;
        end
    end

    // Colour select: blanking, starved-pixel magenta, stream pixel, or test bars.
    always_comb begin
        w_pix24 = 24'(w_pix);
        if (!w_active)                             w_rgb = 24'h000000;
        else if (w_under)                          w_rgb = 24'hFF00FF;
        else if (w_stream)                         w_rgb = (PIX_W == 24) ? w_pix24 : {3{w_pix24[7:0]}};
        else if (int'(r_hcnt) < H_ACTIVE / 3)      w_rgb = 24'hFF0000;
        else if (int'(r_hcnt) < 2 * H_ACTIVE / 3)  w_rgb = 24'h00FF00;
        else                                       w_rgb = 24'h0000FF;
    end

    // Registered pins and status.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            VGA_HS_n     <= 1'b1;
            VGA_VS_n     <= 1'b1;
            VGA_red      <= 8'h00;
            VGA_green    <= 8'h00;
            VGA_blue     <= 8'h00;
            underflow    <= 1'b0;
            frames_shown <= 16'd0;
        end else begin
            VGA_HS_n <= !((int'(r_hcnt) >= H_ACTIVE + H_FP) && (int'(r_hcnt) < H_ACTIVE + H_FP + H_SYNC));
            VGA_VS_n <= !((int'(r_vcnt) >= V_ACTIVE + V_FP) && (int'(r_vcnt) < V_ACTIVE + V_FP + V_SYNC));
            {VGA_red, VGA_green, VGA_blue} <= w_rgb;
            if (w_under) underflow <= 1'b1;
            if (w_frame_end && w_streaming) frames_shown <= frames_shown + 1'b1;
        end
    end
endmodule

// File: tb/tb_display_stream.sv
// Directed bench for display_stream on a 12x7 raster: timing table, 8- and
// 24-bit streaming, underflow, frame-end stop, FIFO limits and async reset.
module tb_display_stream;
    localparam int FT = 84;

    logic vgaclk = 1'b0;
    logic rst    = 1'b1;
    always #5 vgaclk = ~vgaclk;

    display_stream_if #(.DATA_W(64)) bus_a ();
    display_stream_if #(.DATA_W(48)) bus_b ();

    logic [4:0]  a_cnt;
    logic        a_hs, a_vs, a_run, a_und;
    logic [7:0]  a_r, a_g, a_b;
    logic [15:0] a_frames;
    logic [2:0]  b_cnt;
    logic        b_hs, b_vs, b_run, b_und;
    logic [7:0]  b_r, b_g, b_b;
    logic [15:0] b_frames;

    display_stream #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DATA_W(64), .PIX_W(8), .FIFO_DEPTH(16), .START_LEVEL(8)
    ) dut_a (
        .vgaclk(vgaclk), .rst(rst), .bus(bus_a), .fifo_count(a_cnt),
        .VGA_HS_n(a_hs), .VGA_VS_n(a_vs), .VGA_red(a_r), .VGA_green(a_g), .VGA_blue(a_b),
        .running(a_run), .underflow(a_und), .frames_shown(a_frames)
    );

    display_stream #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DATA_W(48), .PIX_W(24), .FIFO_DEPTH(4), .START_LEVEL(1)
    ) dut_b (
        .vgaclk(vgaclk), .rst(rst), .bus(bus_b), .fifo_count(b_cnt),
        .VGA_HS_n(b_hs), .VGA_VS_n(b_vs), .VGA_red(b_r), .VGA_green(b_g), .VGA_blue(b_b),
        .running(b_run), .underflow(b_und), .frames_shown(b_frames)
    );

    // Bench-side cycle count since reset release; pins sampled after edge n show raster position n-1.
    int ncyc;
    always @(posedge vgaclk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if ((ncyc - 1) % FT == p) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout waiting for raster position %0d", p);
        end
    endtask

    task automatic check_a(input string name, input logic hs, input logic vs, input logic [23:0] rgb);
        check(name, {6'd0, a_hs, a_vs, a_r, a_g, a_b}, {6'd0, hs, vs, rgb});
    endtask

    typedef struct {
        int          pos;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;
    vec_t tbl [16];

    initial begin
        tbl = '{
            '{0,  1'b1, 1'b1, 24'hFF0000}, '{1,  1'b1, 1'b1, 24'hFF0000},
            '{2,  1'b1, 1'b1, 24'h00FF00}, '{4,  1'b1, 1'b1, 24'h00FF00},
            '{5,  1'b1, 1'b1, 24'h0000FF}, '{7,  1'b1, 1'b1, 24'h0000FF},
            '{8,  1'b1, 1'b1, 24'h000000}, '{9,  1'b0, 1'b1, 24'h000000},
            '{10, 1'b0, 1'b1, 24'h000000}, '{11, 1'b1, 1'b1, 24'h000000},
            '{13, 1'b1, 1'b1, 24'hFF0000}, '{48, 1'b1, 1'b1, 24'h000000},
            '{60, 1'b1, 1'b0, 24'h000000}, '{69, 1'b0, 1'b0, 24'h000000},
            '{72, 1'b1, 1'b1, 24'h000000}, '{83, 1'b1, 1'b1, 24'h000000}
        };
        bus_a.cmd = 32'd0; bus_a.cmd_valid = 1'b0; bus_a.s_data = 64'd0; bus_a.s_valid = 1'b0;
        bus_b.cmd = 32'd0; bus_b.cmd_valid = 1'b0; bus_b.s_data = 48'd0; bus_b.s_valid = 1'b0;

        repeat (3) step();
        check_a("reset_pins", 1'b1, 1'b1, 24'h000000);
        check("reset_status", {26'd0, a_und, a_run, a_cnt}, 32'd0);
        check("reset_frames", {16'd0, a_frames}, 32'd0);
        check("reset_ready", {30'd0, bus_a.s_ready, bus_a.cmd_ready}, 32'd3);
        @(negedge vgaclk);
        rst = 1'b0;

        // Raster timing and idle test pattern.
        for (int i = 0; i < 16; i++) begin
            wait_pos(tbl[i].pos);
            check_a($sformatf("timing_pos%0d", tbl[i].pos), tbl[i].hs, tbl[i].vs, tbl[i].rgb);
        end

        // 24-bit pixels on the second engine.
        bus_b.s_data = 48'hFF000000FF00; bus_b.s_valid = 1'b1;
        bus_b.cmd = 32'd1; bus_b.cmd_valid = 1'b1;
        step();
        bus_b.s_valid = 1'b0; bus_b.cmd_valid = 1'b0;
        wait_pos(0);
        check("b24_pix0", {8'd0, b_r, b_g, b_b}, 32'hFF0000);
        step();
        check("b24_pix1", {8'd0, b_r, b_g, b_b}, 32'h00FF00);
        step();
        check("b24_starved", {7'd0, b_und, b_r, b_g, b_b}, 32'h1FF00FF);

        // 8-bit stream: preload eight words, start, check unpack order.
        bus_a.s_data = 64'h0001020304050607; bus_a.s_valid = 1'b1;
        bus_a.cmd = 32'd1; bus_a.cmd_valid = 1'b1;
        step();
        bus_a.cmd_valid = 1'b0;
        repeat (7) step();
        bus_a.s_valid = 1'b0;
        check("preload_count", {27'd0, a_cnt}, 32'd8);
        wait_pos(0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check_a($sformatf("stream_pix%0d", i), 1'b1, 1'b1, {3{i[7:0]}});
        end
        check("stream_running", {31'd0, a_run}, 32'd1);
        wait_pos(13);
        check_a("stream_line1_pix1", 1'b1, 1'b1, 24'h010101);
        wait_pos(5);
        check("frames_after_one", {16'd0, a_frames}, 32'd1);
        check_a("frame2_pix5", 1'b1, 1'b1, 24'h050505);

        // Starvation mid-line, then a refill resumes without a timing slip.
        wait_pos(0);
        check("underflow_flag", {15'd0, a_und, a_frames}, 32'h10002);
        check_a("underflow_pix0", 1'b1, 1'b1, 24'hFF00FF);
        wait_pos(2);
        bus_a.s_data = 64'h1011121314151617; bus_a.s_valid = 1'b1;
        step();
        bus_a.s_valid = 1'b0;
        check_a("underflow_pix3", 1'b1, 1'b1, 24'hFF00FF);
        step();
        check_a("refill_pix4", 1'b1, 1'b1, 24'h101010);
        step();
        check_a("refill_pix5", 1'b1, 1'b1, 24'h111111);
        wait_pos(12);
        check_a("refill_next_line", 1'b1, 1'b1, 24'h141414);

        // STOP at line 1: stream to frame end, then idle with flushed FIFO.
        bus_a.cmd = 32'd2; bus_a.cmd_valid = 1'b1;
        bus_a.s_data = 64'hA5A5A5A5A5A5A5A5; bus_a.s_valid = 1'b1;
        step();
        bus_a.cmd_valid = 1'b0;
        repeat (3) step();
        bus_a.s_valid = 1'b0;
        check_a("stopping_pix16", 1'b1, 1'b1, 24'hA5A5A5);
        wait_pos(40);
        check_a("stopping_pix40", 1'b1, 1'b1, 24'hA5A5A5);
        check("stopping_state", {26'd0, a_run, a_cnt}, 32'h21);
        wait_pos(82);
        bus_a.s_data = 64'hDEADBEEFDEADBEEF; bus_a.s_valid = 1'b1;
        step();
        bus_a.s_valid = 1'b0;
        check("stop_flush", {10'd0, a_run, a_cnt, a_frames}, {10'd0, 1'b0, 5'd0, 16'd3});
        step();
        check_a("stop_pattern_red", 1'b1, 1'b1, 24'hFF0000);
        wait_pos(3);
        check_a("stop_pattern_green", 1'b1, 1'b1, 24'h00FF00);

        // FIFO full, then a simultaneous read and write.
        bus_a.s_data = 64'h0001020304050607; bus_a.s_valid = 1'b1;
        repeat (18) step();
        check("fifo_full", {26'd0, bus_a.s_ready, a_cnt}, 32'd16);
        bus_a.s_valid = 1'b0;
        bus_a.cmd = 32'd1; bus_a.cmd_valid = 1'b1;
        step();
        bus_a.cmd_valid = 1'b0;
        wait_pos(0);
        check("restart_running", {31'd0, a_run}, 32'd1);
        wait_pos(6);
        check("count_after_read", {27'd0, a_cnt}, 32'd15);
        bus_a.s_valid = 1'b1;
        step();
        bus_a.s_valid = 1'b0;
        check("count_rd_wr", {27'd0, a_cnt}, 32'd15);
        check_a("restart_pix7", 1'b1, 1'b1, 24'h070707);

        // Asynchronous reset mid-frame clears outputs without waiting for an edge.
        wait_pos(13);
        check_a("prereset_pix", 1'b1, 1'b1, 24'h010101);
        #2;
        rst = 1'b1;
        #1;
        check_a("async_rst_pins", 1'b1, 1'b1, 24'h000000);
        check("async_rst_status", {25'd0, b_und, a_und, a_run, a_cnt}, 32'd0);
        check("async_rst_frames", {16'd0, a_frames}, 32'd0);
        @(negedge vgaclk);
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
